iq_frame_packer: RTL and testbench

- Parametrised successor to the snapshot/trigger/framing path between the CIC decimators and the transmit FIFO.
- Captures N_CH I/Q sample pairs on each rising edge of the decimated clock, with a per-channel enable mask latched at capture.
- Serialises the capture into a framed byte stream over a valid/ready handshake that feeds the transmit FIFO/UART.
- Adds sequence numbering, variable payload length, checksum and overrun detection.

---
 rtl/iq_frame_packer_pkg.sv | 32 +++
 rtl/iq_frame_packer_edge_trigger.sv | 23 ++
 rtl/iq_frame_packer.sv | 210 +++++++++++++++++++++
 tb/tb_iq_frame_packer.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/iq_frame_packer_pkg.sv
// Shared types and helpers for the I/Q frame packer: state encoding, default
// framing bytes and small arithmetic helpers.
package iq_frame_packer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SOF,
    ST_ID,
    ST_SEQ,
    ST_LEN,
    ST_PAYLOAD,
    ST_CHK
  } state_t;

  localparam logic [7:0] DEF_SOF_BYTE = 8'hAA;
  localparam logic [7:0] DEF_FRAME_ID = 8'h01;

  function automatic int unsigned bytes_per_sample(input int unsigned width);
    return width / 8;
  endfunction

  // Population count of a channel mask (up to 8 channels)
  function automatic logic [3:0] popcount(input logic [7:0] m);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n = n + 4'(m[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/iq_frame_packer_edge_trigger.sv
// Registered rising-edge detector with enable; the pulse lands one clock after
// the input is first sampled high.
module iq_frame_packer_edge_trigger (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic sig,
  output logic pulse
);

  logic sig_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sig_q <= 1'b0;
      pulse <= 1'b0;
    end else begin
      sig_q <= sig;
      pulse <= sig & ~sig_q & en;
    end
  end

endmodule

// File: rtl/iq_frame_packer.sv
// Snapshots N_CH I/Q pairs on each decimated-clock edge and serialises them as
// SOF, ID, SEQ, LEN, payload, CHK over a byte-wide valid/ready stream.
module iq_frame_packer
  import iq_frame_packer_pkg::*;
#(
  parameter int unsigned N_CH         = 2,
  parameter int unsigned SAMPLE_WIDTH = 16,
  parameter logic [7:0]  FRAME_ID     = DEF_FRAME_ID,
  parameter logic [7:0]  SOF_BYTE     = DEF_SOF_BYTE
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_en,
  input  logic                         i_dclk,
  input  logic [N_CH*2*SAMPLE_WIDTH-1:0] i_data,
  input  logic [N_CH-1:0]              i_ch_mask,
  input  logic                         i_ready,
  output logic [7:0]                   o_data,
  output logic                         o_valid,
  output logic                         o_busy,
  output logic [7:0]                   o_seq,
  output logic                         o_overrun
);

  localparam int unsigned BPS      = bytes_per_sample(SAMPLE_WIDTH);
  localparam int unsigned CH_BYTES = 2 * BPS;
  localparam int unsigned DW       = N_CH * 2 * SAMPLE_WIDTH;
  localparam int unsigned CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned SUB_W    = $clog2(CH_BYTES);

  state_t            state, state_next;
  logic [CH_W-1:0]   ch, ch_next;
  logic [SUB_W-1:0]  sub, sub_next;
  logic [7:0]        rem, rem_next;
  logic [7:0]        chk, chk_next;
  logic [7:0]        chk_acc;
  logic [7:0]        len;
  logic [7:0]        len_d;
  logic [7:0]        data_next;
  logic [DW-1:0]     data_q;
  logic [N_CH-1:0]   mask_q;
  logic [7:0]        seq_cnt;
  logic              trig;
  logic              capture;
  logic              adv;

  // Lowest enabled channel at or above start
  function automatic logic [CH_W-1:0] first_from(input logic [N_CH-1:0] m,
                                                 input int unsigned start);
    logic [CH_W-1:0] r;
    logic            found;
    r     = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (!found && i >= start && m[i]) begin
        r     = CH_W'(i);
        found = 1'b1;
      end
    end
    return r;
  endfunction

  // Byte s (0 = MSB of I) of channel c; channel 0 sits in the MSBs
  function automatic logic [7:0] pick(input logic [DW-1:0] d,
                                      input logic [CH_W-1:0] c,
                                      input logic [SUB_W-1:0] s);
    int unsigned   k;
    logic [DW-1:0] sh;
    k  = (N_CH - 1 - 32'(c)) * CH_BYTES + (CH_BYTES - 1 - 32'(s));
    sh = d >> (8 * k);
    return sh[7:0];
  endfunction

  iq_frame_packer_edge_trigger u_trig (
    .clk   (i_clk),
    .rst   (i_rst),
    .en    (i_en),
    .sig   (i_dclk),
    .pulse (trig)
  );

  assign len_d = 8'(32'(popcount(8'(i_ch_mask))) * CH_BYTES);
  assign adv   = o_valid & i_ready;

  // Next-state, next-byte and running checksum
  always_comb begin
    state_next = state;
    ch_next    = ch;
    sub_next   = sub;
    rem_next   = rem;
    chk_next   = chk;
    data_next  = o_data;
    capture    = 1'b0;
    chk_acc    = chk ^ o_data;

    case (state)
      ST_IDLE: begin
        if (trig) begin
          capture    = 1'b1;
          chk_next   = '0;
          state_next = ST_SOF;
          data_next  = SOF_BYTE;
        end
      end
      ST_SOF: begin
        if (adv) begin
          state_next = ST_ID;
          data_next  = FRAME_ID;
        end
      end
      ST_ID: begin
        if (adv) begin
          chk_next   = chk_acc;
          state_next = ST_SEQ;
          data_next  = o_seq;
        end
      end
      ST_SEQ: begin
        if (adv) begin
          chk_next   = chk_acc;
          state_next = ST_LEN;
          data_next  = len;
        end
      end
      ST_LEN: begin
        if (adv) begin
          chk_next = chk_acc;
          if (len == 8'd0) begin
            state_next = ST_CHK;
            data_next  = chk_acc;
          end else begin
            state_next = ST_PAYLOAD;
            ch_next    = first_from(mask_q, 0);
            sub_next   = '0;
            rem_next   = len;
            data_next  = pick(data_q, first_from(mask_q, 0), '0);
          end
        end
      end
      ST_PAYLOAD: begin
        if (adv) begin
          chk_next = chk_acc;
          if (rem == 8'd1) begin
            state_next = ST_CHK;
            data_next  = chk_acc;
          end else begin
            rem_next = 8'(rem - 8'd1);
            if (32'(sub) == CH_BYTES - 1) begin
              ch_next  = first_from(mask_q, 32'(ch) + 1);
              sub_next = '0;
            end else begin
              sub_next = SUB_W'(sub + 1'b1);
            end
            data_next = pick(data_q, ch_next, sub_next);
          end
        end
      end
      ST_CHK: begin
        if (adv) begin
          state_next = ST_IDLE;
          data_next  = '0;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State, datapath and status registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= ST_IDLE;
      ch        <= '0;
      sub       <= '0;
      rem       <= '0;
      chk       <= '0;
      len       <= '0;
      data_q    <= '0;
      mask_q    <= '0;
      seq_cnt   <= '0;
      o_seq     <= '0;
      o_data    <= '0;
      o_valid   <= 1'b0;
      o_busy    <= 1'b0;
      o_overrun <= 1'b0;
    end else begin
      state   <= state_next;
      ch      <= ch_next;
      sub     <= sub_next;
      rem     <= rem_next;
      chk     <= chk_next;
      o_data  <= data_next;
      o_valid <= (state_next != ST_IDLE);
      o_busy  <= (state_next != ST_IDLE);
      if (capture) begin
        data_q <= i_data;
        mask_q <= i_ch_mask;
        len    <= len_d;
        o_seq  <= seq_cnt;
      end
      // Dropped triggers still consume a sequence number so gaps are visible
      if (trig) begin
        seq_cnt <= seq_cnt + 8'd1;
      end
      if (trig && state != ST_IDLE) begin
        o_overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_iq_frame_packer.sv
// Directed bench for iq_frame_packer: table of frames plus overrun, enable and
// mid-frame reset sequences.
module tb_iq_frame_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        dclk;
  logic [63:0] data;
  logic [1:0]  mask;
  logic        ready;
  logic [7:0]  o_data;
  logic        o_valid;
  logic        o_busy;
  logic [7:0]  o_seq;
  logic        o_overrun;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [1:0]        mask;
    logic [63:0]       data;
    int                n;
    logic [0:12][7:0]  b;
    logic [7:0]        seq;
    bit                bp;
    int                ovr_at;
  } vec_t;

  vec_t tv[8];

  localparam logic [63:0] D0 = 64'h1234_5678_9ABC_DEF0;

  iq_frame_packer #(
    .N_CH(2), .SAMPLE_WIDTH(16), .FRAME_ID(8'h01), .SOF_BYTE(8'hAA)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_en      (en),
    .i_dclk    (dclk),
    .i_data    (data),
    .i_ch_mask (mask),
    .i_ready   (ready),
    .o_data    (o_data),
    .o_valid   (o_valid),
    .o_busy    (o_busy),
    .o_seq     (o_seq),
    .o_overrun (o_overrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // Trigger one frame and collect its bytes, checking each against the table
  task automatic run_frame(input vec_t v);
    int   k;
    int   it;
    bit   held;
    logic [7:0] hd;
    logic rdy;
    data = v.data;
    mask = v.mask;
    dclk = 1'b1;
    tick();
    check("lat0_valid", 32'(o_valid), 32'd0);
    tick();
    dclk = 1'b0;
    check("lat1_valid", 32'(o_valid), 32'd1);
    check("seq_out", 32'(o_seq), 32'(v.seq));
    k    = 0;
    it   = 0;
    held = 1'b0;
    hd   = '0;
    while (k < v.n && it < 300) begin
      rdy   = v.bp ? 1'($urandom_range(0, 1)) : 1'b1;
      ready = rdy;
      if (v.ovr_at > 0 && it == v.ovr_at)     dclk = 1'b1;
      if (v.ovr_at > 0 && it == v.ovr_at + 2) dclk = 1'b0;
      if (held) begin
        check("hold_valid", 32'(o_valid), 32'd1);
        check("hold_data", 32'(o_data), 32'(hd));
      end
      held = o_valid && !rdy;
      hd   = o_data;
      if (o_valid && rdy) begin
        check($sformatf("byte%0d", k), 32'(o_data), 32'(v.b[k]));
        k++;
      end
      tick();
      it++;
    end
    ready = 1'b1;
    dclk  = 1'b0;
    check("byte_count", 32'(k), 32'(v.n));
    if (!v.bp) check("throughput", 32'(it), 32'(v.n));
    check("end_busy", 32'(o_busy), 32'd0);
    check("end_valid", 32'(o_valid), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    rst   = 1'b1;
    en    = 1'b1;
    dclk  = 1'b0;
    data  = '0;
    mask  = '0;
    ready = 1'b1;

    tv[0] = '{2'b11, D0, 13, {8'hAA,8'h01,8'h00,8'h08,8'h12,8'h34,8'h56,8'h78,8'h9A,8'hBC,8'hDE,8'hF0,8'h09}, 8'h00, 1'b0, 0};
    tv[1] = '{2'b10, D0, 9,  {8'hAA,8'h01,8'h01,8'h04,8'h9A,8'hBC,8'hDE,8'hF0,8'h0C,32'h0}, 8'h01, 1'b0, 0};
    tv[2] = '{2'b00, D0, 5,  {8'hAA,8'h01,8'h02,8'h00,8'h03,64'h0}, 8'h02, 1'b0, 0};
    tv[3] = '{2'b01, D0, 9,  {8'hAA,8'h01,8'h03,8'h04,8'h12,8'h34,8'h56,8'h78,8'h0E,32'h0}, 8'h03, 1'b0, 0};
    tv[4] = '{2'b11, D0, 13, {8'hAA,8'h01,8'h04,8'h08,8'h12,8'h34,8'h56,8'h78,8'h9A,8'hBC,8'hDE,8'hF0,8'h0D}, 8'h04, 1'b1, 0};
    tv[5] = '{2'b11, D0, 13, {8'hAA,8'h01,8'h05,8'h08,8'h12,8'h34,8'h56,8'h78,8'h9A,8'hBC,8'hDE,8'hF0,8'h0C}, 8'h05, 1'b0, 6};
    tv[6] = '{2'b10, D0, 9,  {8'hAA,8'h01,8'h07,8'h04,8'h9A,8'hBC,8'hDE,8'hF0,8'h0A,32'h0}, 8'h07, 1'b0, 0};
    tv[7] = '{2'b01, D0, 9,  {8'hAA,8'h01,8'h08,8'h04,8'h12,8'h34,8'h56,8'h78,8'h05,32'h0}, 8'h08, 1'b0, 0};

    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_data", 32'(o_data), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_seq", 32'(o_seq), 32'd0);
    check("rst_overrun", 32'(o_overrun), 32'd0);

    for (int i = 0; i < 5; i++) begin
      run_frame(tv[i]);
      tick();
    end
    check("no_overrun", 32'(o_overrun), 32'd0);

    // Second edge lands mid-payload: frame intact, next SEQ skips one
    run_frame(tv[5]);
    check("overrun_set", 32'(o_overrun), 32'd1);
    tick();
    run_frame(tv[6]);
    check("overrun_sticky", 32'(o_overrun), 32'd1);
    tick();

    // Edge with trigger disabled is ignored entirely
    en   = 1'b0;
    dclk = 1'b1;
    repeat (2) tick();
    dclk = 1'b0;
    repeat (3) tick();
    check("en0_valid", 32'(o_valid), 32'd0);
    check("en0_busy", 32'(o_busy), 32'd0);
    check("en0_seq", 32'(o_seq), 32'h07);
    en = 1'b1;
    tick();
    run_frame(tv[7]);
    tick();

    // Reset in the middle of the payload
    data  = D0;
    mask  = 2'b11;
    ready = 1'b1;
    dclk  = 1'b1;
    repeat (2) tick();
    dclk = 1'b0;
    repeat (6) tick();
    check("pre_rst_valid", 32'(o_valid), 32'd1);
    check("pre_rst_seq", 32'(o_seq), 32'h09);
    rst = 1'b1;
    tick();
    check("mid_rst_valid", 32'(o_valid), 32'd0);
    check("mid_rst_seq", 32'(o_seq), 32'd0);
    check("mid_rst_overrun", 32'(o_overrun), 32'd0);
    check("mid_rst_busy", 32'(o_busy), 32'd0);
    rst = 1'b0;
    tick();
    run_frame(tv[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
